// File: rtl/router_hdr_monitor_pkg.sv
// Shared types and limits for the router header monitor.
// The per-channel FSM state encoding lives here so debug logic can decode it.
package router_hdr_monitor_pkg;

  typedef enum logic [1:0] {HDR_IDLE, HDR_ADDR, HDR_PAYLOAD} hdr_state_t;

  localparam int HDR_MAX_CH = 32;

endpackage

// File: rtl/router_hdr_chan.sv
// One channel of the header monitor: rise detect, FSM, bit counter and address shifter.
// Completion and abort are reported combinationally for the edge at which they occur.
module router_hdr_chan
  import router_hdr_monitor_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_stream,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_abort_pulse,
  output hdr_state_t        o_state
);

  localparam int BCNT_W = $clog2(ADDR_W + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(ADDR_W - 1);

  hdr_state_t        r_state;
  logic              r_valid_q;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [ADDR_W-1:0] r_shift;

  logic              w_rise;
  logic              w_last;
  logic [ADDR_W-1:0] w_shift_next;

  assign w_rise       = i_valid & ~r_valid_q;
  assign w_last       = (r_state == HDR_ADDR) && (r_bit_cnt == LAST_BIT);
  // Truncating cast drops the oldest bit, giving an MSB-first shift for any ADDR_W.
  assign w_shift_next = ADDR_W'({r_shift, i_stream});

  assign o_done        = w_last & i_valid;
  assign o_addr        = w_shift_next;
  assign o_abort_pulse = (r_state == HDR_ADDR) & ~i_valid;
  assign o_state       = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HDR_IDLE;
      r_valid_q <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_valid_q <= i_valid;
      case (r_state)
        HDR_IDLE: begin
          if (w_rise) begin
            r_state   <= HDR_ADDR;
            r_bit_cnt <= '0;
            r_shift   <= '0;
          end
        end
        HDR_ADDR: begin
          if (!i_valid) begin
            r_state <= HDR_IDLE;
          end else begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last) r_state <= HDR_PAYLOAD;
          end
        end
        HDR_PAYLOAD: begin
          if (!i_valid) r_state <= HDR_IDLE;
        end
        default: r_state <= HDR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/router_hdr_monitor.sv
// Header monitor for the router's serial inputs: per-channel FSMs plus sticky
// coverage/error flags and a saturating count of completed legal headers.
module router_hdr_monitor
  import router_hdr_monitor_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          valid,
  input  logic [NUM_CH-1:0]          stream,
  input  logic                       clear,
  output logic [NUM_CH-1:0]          hdr_done,
  output logic [NUM_CH*ADDR_W-1:0]   hdr_addr,
  output logic [NUM_CH-1:0]          passthru,
  output logic [NUM_CH*NUM_CH-1:0]   cover_map,
  output logic [NUM_CH-1:0]          illegal,
  output logic [NUM_CH-1:0]          aborted,
  output logic [CNT_W-1:0]           hdr_count,
  output logic [2*NUM_CH-1:0]        dbg_state
);

  if (ADDR_W < $clog2(NUM_CH)) begin : g_bad_addr_w
    $error("router_hdr_monitor: ADDR_W too narrow for NUM_CH");
  end
  if (NUM_CH < 2 || NUM_CH > HDR_MAX_CH) begin : g_bad_num_ch
    $error("router_hdr_monitor: NUM_CH out of range");
  end

  localparam int POP_W = $clog2(NUM_CH + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [ADDR_W:0]  NUM_CH_LIM = (ADDR_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_abort;
  logic [NUM_CH-1:0] w_legal;
  logic [ADDR_W-1:0] w_addr [NUM_CH];
  hdr_state_t        w_state [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    router_hdr_chan #(.ADDR_W(ADDR_W)) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_valid       (valid[g]),
      .i_stream      (stream[g]),
      .o_done        (w_done[g]),
      .o_addr        (w_addr[g]),
      .o_abort_pulse (w_abort[g]),
      .o_state       (w_state[g])
    );
    assign w_legal[g]           = w_done[g] && ({1'b0, w_addr[g]} < NUM_CH_LIM);
    assign dbg_state[g*2 +: 2]  = w_state[g];
  end

  logic [NUM_CH-1:0]        r_hdr_done;
  logic [NUM_CH*ADDR_W-1:0] r_hdr_addr;
  logic [NUM_CH-1:0]        r_passthru;
  logic [NUM_CH*NUM_CH-1:0] r_cover_map;
  logic [NUM_CH-1:0]        r_illegal;
  logic [NUM_CH-1:0]        r_aborted;
  logic [CNT_W-1:0]         r_hdr_count;

  logic [POP_W-1:0] w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_count_next;

  // Clear zeroes the base, so a same-cycle increment restarts from 0.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop = w_pop + {{(POP_W-1){1'b0}}, w_legal[i]};
    end
    w_sum        = SUM_W'(clear ? '0 : r_hdr_count) + SUM_W'(w_pop);
    w_count_next = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(w_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_done  <= '0;
      r_hdr_addr  <= '0;
      r_passthru  <= '0;
      r_cover_map <= '0;
      r_illegal   <= '0;
      r_aborted   <= '0;
      r_hdr_count <= '0;
    end else begin
      r_hdr_done  <= w_done;
      r_hdr_count <= w_count_next;
      if (clear) begin
        r_passthru  <= '0;
        r_cover_map <= '0;
        r_illegal   <= '0;
        r_aborted   <= '0;
      end
      // Sets come after the clear so they win when both happen together.
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_abort[i]) r_aborted[i] <= 1'b1;
        if (w_done[i]) begin
          r_hdr_addr[i*ADDR_W +: ADDR_W] <= w_addr[i];
          if (w_legal[i]) begin
            for (int j = 0; j < NUM_CH; j++) begin
              if (w_addr[i] == ADDR_W'(j)) r_cover_map[i*NUM_CH + j] <= 1'b1;
            end
            if (w_addr[i] == ADDR_W'(i)) r_passthru[i] <= 1'b1;
          end else begin
            r_illegal[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign hdr_done  = r_hdr_done;
  assign hdr_addr  = r_hdr_addr;
  assign passthru  = r_passthru;
  assign cover_map = r_cover_map;
  assign illegal   = r_illegal;
  assign aborted   = r_aborted;
  assign hdr_count = r_hdr_count;

endmodule

// File: tb/tb_router_hdr_monitor.sv
// Directed/random bench for router_hdr_monitor: an 8-channel default instance
// and a 5-channel instance with a 2-bit counter for illegal/clear/saturation.
module tb_router_hdr_monitor;

  localparam int NA  = 8;
  localparam int NB  = 5;
  localparam int AW  = 3;
  localparam int CWB = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n_a, rst_n_b;

  // ---------------- DUT A (defaults) ----------------
  logic [NA-1:0]    valid_a, stream_a, hdr_done_a, passthru_a, illegal_a, aborted_a;
  logic             clear_a;
  logic [NA*AW-1:0] hdr_addr_a;
  logic [NA*NA-1:0] cover_a;
  logic [15:0]      hdr_count_a;
  logic [2*NA-1:0]  dbg_a;

  router_hdr_monitor dut_a (
    .clk(clk), .rst_n(rst_n_a), .valid(valid_a), .stream(stream_a), .clear(clear_a),
    .hdr_done(hdr_done_a), .hdr_addr(hdr_addr_a), .passthru(passthru_a),
    .cover_map(cover_a), .illegal(illegal_a), .aborted(aborted_a),
    .hdr_count(hdr_count_a), .dbg_state(dbg_a)
  );

  // ---------------- DUT B (NUM_CH=5, CNT_W=2) ----------------
  logic [NB-1:0]    valid_b, stream_b, hdr_done_b, passthru_b, illegal_b, aborted_b;
  logic             clear_b;
  logic [NB*AW-1:0] hdr_addr_b;
  logic [NB*NB-1:0] cover_b;
  logic [CWB-1:0]   hdr_count_b;
  logic [2*NB-1:0]  dbg_b;

  router_hdr_monitor #(.NUM_CH(NB), .ADDR_W(AW), .CNT_W(CWB)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .valid(valid_b), .stream(stream_b), .clear(clear_b),
    .hdr_done(hdr_done_b), .hdr_addr(hdr_addr_b), .passthru(passthru_b),
    .cover_map(cover_b), .illegal(illegal_b), .aborted(aborted_b),
    .hdr_count(hdr_count_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_qa[$];  // {channel[4:0], addr[2:0]}
  logic [7:0] exp_qb[$];

  logic [NA-1:0]    m_pass_a, m_ill_a, m_abt_a;
  logic [NA*NA-1:0] m_cov_a;
  logic [NA*AW-1:0] m_addr_a;
  int               m_cnt_a;
  logic [NB-1:0]    m_pass_b, m_ill_b, m_abt_b;
  logic [NB*NB-1:0] m_cov_b;
  logic [NB*AW-1:0] m_addr_b;
  int               m_cnt_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops one expected completion per hdr_done bit, lowest channel first.
  always @(negedge clk) begin
    logic [7:0] e;
    for (int i = 0; i < NA; i++) begin
      if (hdr_done_a[i] === 1'b1) begin
        if (exp_qa.size() == 0) chk("a_unexpected_done", 64'(i), 64'hFFFF);
        else begin
          e = exp_qa.pop_front();
          chk("a_done_ch", 64'(i), 64'(e[7:3]));
          chk("a_done_addr", 64'(hdr_addr_a[i*AW +: AW]), 64'(e[2:0]));
        end
      end
    end
    if (hdr_done_a === 8'hFF) chk("a_batch_count_one_cycle", 64'(hdr_count_a), 64'(m_cnt_a));
    for (int i = 0; i < NB; i++) begin
      if (hdr_done_b[i] === 1'b1) begin
        if (exp_qb.size() == 0) chk("b_unexpected_done", 64'(i), 64'hFFFF);
        else begin
          e = exp_qb.pop_front();
          chk("b_done_ch", 64'(i), 64'(e[7:3]));
          chk("b_done_addr", 64'(hdr_addr_b[i*AW +: AW]), 64'(e[2:0]));
        end
      end
    end
  end

  task automatic zero_model_a();
    m_pass_a = '0; m_ill_a = '0; m_abt_a = '0; m_cov_a = '0; m_addr_a = '0; m_cnt_a = 0;
  endtask

  task automatic zero_model_b();
    m_pass_b = '0; m_ill_b = '0; m_abt_b = '0; m_cov_b = '0; m_addr_b = '0; m_cnt_b = 0;
  endtask

  task automatic check_a(input string tag);
    chk({tag, "_a_done"}, 64'(hdr_done_a), 64'(0));
    chk({tag, "_a_addr"}, 64'(hdr_addr_a), 64'(m_addr_a));
    chk({tag, "_a_pass"}, 64'(passthru_a), 64'(m_pass_a));
    chk({tag, "_a_cover"}, cover_a, m_cov_a);
    chk({tag, "_a_illegal"}, 64'(illegal_a), 64'(m_ill_a));
    chk({tag, "_a_aborted"}, 64'(aborted_a), 64'(m_abt_a));
    chk({tag, "_a_count"}, 64'(hdr_count_a), 64'(m_cnt_a));
    chk({tag, "_a_state"}, 64'(dbg_a), 64'(0));
  endtask

  task automatic check_b(input string tag);
    chk({tag, "_b_done"}, 64'(hdr_done_b), 64'(0));
    chk({tag, "_b_addr"}, 64'(hdr_addr_b), 64'(m_addr_b));
    chk({tag, "_b_pass"}, 64'(passthru_b), 64'(m_pass_b));
    chk({tag, "_b_cover"}, 64'(cover_b), 64'(m_cov_b));
    chk({tag, "_b_illegal"}, 64'(illegal_b), 64'(m_ill_b));
    chk({tag, "_b_aborted"}, 64'(aborted_b), 64'(m_abt_b));
    chk({tag, "_b_count"}, 64'(hdr_count_b), 64'(m_cnt_b));
    chk({tag, "_b_state"}, 64'(dbg_b), 64'(0));
  endtask

  // ---------------- drivers ----------------
  // nbits < AW drops valid early (abort). Returns one cycle after valid falls.
  task automatic send_a(input logic [NA-1:0] mask, input logic [NA*AW-1:0] addrs, input int nbits);
    logic [AW-1:0] a;
    for (int ch = 0; ch < NA; ch++) begin
      if (mask[ch]) begin
        a = addrs[ch*AW +: AW];
        if (nbits == AW) begin
          exp_qa.push_back({5'(ch), a});
          m_addr_a[ch*AW +: AW] = a;
          if (int'(a) < NA) begin
            m_cov_a[ch*NA + int'(a)] = 1'b1;
            if (int'(a) == ch) m_pass_a[ch] = 1'b1;
            if (m_cnt_a < 65535) m_cnt_a++;
          end else m_ill_a[ch] = 1'b1;
        end else m_abt_a[ch] = 1'b1;
      end
    end
    @(negedge clk); valid_a = valid_a | mask;
    for (int b = AW - 1; b >= AW - nbits; b--) begin
      @(negedge clk);
      for (int ch = 0; ch < NA; ch++) if (mask[ch]) stream_a[ch] = addrs[ch*AW + b];
    end
    @(negedge clk); valid_a = valid_a & ~mask; stream_a = stream_a & ~mask;
    @(negedge clk);
  endtask

  task automatic send_b(input logic [NB-1:0] mask, input logic [NB*AW-1:0] addrs, input int nbits,
                        input bit clr);
    logic [AW-1:0] a;
    int tmp;
    if (clr) begin
      m_pass_b = '0; m_ill_b = '0; m_abt_b = '0; m_cov_b = '0; m_cnt_b = 0;
    end
    tmp = m_cnt_b;
    for (int ch = 0; ch < NB; ch++) begin
      if (mask[ch]) begin
        a = addrs[ch*AW +: AW];
        if (nbits == AW) begin
          exp_qb.push_back({5'(ch), a});
          m_addr_b[ch*AW +: AW] = a;
          if (int'(a) < NB) begin
            m_cov_b[ch*NB + int'(a)] = 1'b1;
            if (int'(a) == ch) m_pass_b[ch] = 1'b1;
            tmp++;
          end else m_ill_b[ch] = 1'b1;
        end else m_abt_b[ch] = 1'b1;
      end
    end
    m_cnt_b = (tmp > 3) ? 3 : tmp;
    @(negedge clk); valid_b = valid_b | mask;
    for (int b = AW - 1; b >= AW - nbits; b--) begin
      @(negedge clk);
      for (int ch = 0; ch < NB; ch++) if (mask[ch]) stream_b[ch] = addrs[ch*AW + b];
      if (clr && b == 0) clear_b = 1'b1;
    end
    @(negedge clk); valid_b = valid_b & ~mask; stream_b = stream_b & ~mask; clear_b = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ch, ad;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    valid_a = '0; stream_a = '0; clear_a = 1'b0;
    valid_b = '0; stream_b = '0; clear_b = 1'b0;
    zero_model_a(); zero_model_b();
    #12;
    check_a("reset"); check_b("reset");
    @(negedge clk); rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);

    send_a(8'h08, 24'(3) << 9, 3);               // ch3 -> 3, pass-through
    check_a("ch3_pass");
    chk("ch3_cover27", 64'(cover_a[27]), 64'(1));
    send_a(8'h20, 24'(2) << 15, 3);              // ch5 -> 2
    check_a("ch5_to2");
    chk("ch5_cover42", 64'(cover_a[42]), 64'(1));
    send_a(8'h04, 24'(5) << 6, 2);               // ch2 aborts after 2 bits
    check_a("ch2_abort");
    send_a(8'h04, 24'(7) << 6, 3);               // ch2 then completes normally
    check_a("ch2_after_abort");
    send_a(8'hFF, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 3);
    check_a("all_pass");
    chk("all_passthru_ff", 64'(passthru_a), 64'hFF);
    for (int k = 0; k < 6; k++) begin
      ch = $urandom_range(0, NA - 1);
      ad = $urandom_range(0, 7);
      send_a(8'(1) << ch, 24'(ad) << (AW * ch), 3);
      check_a("random");
    end

    send_b(5'b00010, 15'(6) << 3, 3, 1'b0);      // ch1 -> 6, illegal for 5 channels
    check_b("b_illegal");
    send_b(5'b00001, 15'(0), 3, 1'b1);           // clear coincides with ch0 pass-through
    check_b("b_clear_set");
    for (int k = 0; k < 4; k++) begin
      send_b(5'b00100, 15'(k % NB) << 6, 3, 1'b0);
      check_b("b_saturate");
    end

    // Reset in the middle of an address field.
    @(negedge clk); valid_b[0] = 1'b1;
    @(negedge clk); stream_b[0] = 1'b1;
    @(negedge clk); stream_b[0] = 1'b0;
    #2 rst_n_b = 1'b0;
    #1 zero_model_b();
    check_b("b_async_reset");
    valid_b = '0; stream_b = '0;
    @(negedge clk); rst_n_b = 1'b1;
    repeat (6) @(negedge clk);
    check_b("b_after_reset");

    chk("a_queue_empty", 64'(exp_qa.size()), 64'(0));
    chk("b_queue_empty", 64'(exp_qb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
